// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with
// activity/completion watchdogs and a programmable post-frame idle gap.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int GAP_CLKS     = 0,
   parameter int TIMEOUT_CLKS = 1200
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic [NUM_REQ-1:0]   i_Req_DV,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]   o_Req_Ack,
   output logic [NUM_REQ-1:0]   o_Req_Done,
   output logic                 o_Err,
   output logic                 o_Busy,
   output logic [2:0]           o_Grant_Id,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done
);

   localparam int CW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CLKS);
   localparam logic [CW-1:0] ACT_LIMIT = CW'(3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_ACT,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t               state, state_nxt;
   logic [2:0]           last, last_nxt;
   logic [2:0]           grant_nxt;
   logic                 tx_dv_nxt;
   logic [7:0]           tx_byte_nxt;
   logic [NUM_REQ-1:0]   ack_nxt, done_nxt;
   logic                 err_nxt, busy_nxt;
   logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
   logic [7:0]           gap_cnt, gap_nxt;

   logic                 win_vld;
   logic [2:0]           win_id;
   logic [7:0]           win_byte;
   logic [NUM_REQ-1:0]   win_oh, grant_oh;

   // Lowest index above last wins; otherwise wrap to the lowest index at or below it.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int r = NUM_REQ - 1; r >= 0; r--) begin
         if (i_Req_DV[r] && (3'(r) <= last)) begin
            win_vld = 1'b1;
            win_id  = 3'(r);
         end
      end
      for (int r = NUM_REQ - 1; r >= 0; r--) begin
         if (i_Req_DV[r] && (3'(r) > last)) begin
            win_vld = 1'b1;
            win_id  = 3'(r);
         end
      end
   end

   always_comb begin
      win_byte = '0;
      win_oh   = '0;
      grant_oh = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (win_id == 3'(r)) begin
            win_byte  = i_Req_Byte[8*r +: 8];
            win_oh[r] = 1'b1;
         end
         grant_oh[r] = (o_Grant_Id == 3'(r));
      end
   end

   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      grant_nxt   = o_Grant_Id;
      tx_dv_nxt   = 1'b0;
      tx_byte_nxt = o_Tx_Byte;
      ack_nxt     = '0;
      done_nxt    = '0;
      err_nxt     = 1'b0;
      cnt_nxt     = cnt;
      gap_nxt     = gap_cnt;
      case (state)
         S_IDLE: begin
            // A transmitter still busy from before a reset blocks new grants.
            if (win_vld && !i_Tx_Active && !i_Tx_Done) begin
               last_nxt    = win_id;
               grant_nxt   = win_id;
               tx_byte_nxt = win_byte;
               tx_dv_nxt   = 1'b1;
               ack_nxt     = win_oh;
               state_nxt   = S_START;
            end
         end
         S_START: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_ACT;
         end
         S_WAIT_ACT: begin
            if (i_Tx_Active) begin
               cnt_nxt   = '0;
               state_nxt = S_WAIT_DONE;
            end else if (cnt == ACT_LIMIT) begin
               err_nxt   = 1'b1;
               gap_nxt   = 8'(GAP_CLKS);
               state_nxt = S_GAP;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_WAIT_DONE: begin
            cnt_nxt = cnt_inc;
            if (i_Tx_Done) begin
               done_nxt  = grant_oh;
               gap_nxt   = 8'(GAP_CLKS);
               state_nxt = S_GAP;
            end else if (cnt_inc == CNT_LIMIT) begin
               err_nxt   = 1'b1;
               gap_nxt   = 8'(GAP_CLKS);
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            // Waiting for Done to drop swallows its second high cycle.
            if ((gap_cnt == 8'd0) && !i_Tx_Done) begin
               state_nxt = S_IDLE;
            end else if (gap_cnt != 8'd0) begin
               gap_nxt = gap_cnt - 8'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= S_IDLE;
         last       <= 3'(NUM_REQ - 1);
         o_Grant_Id <= '0;
         o_Tx_DV    <= 1'b0;
         o_Tx_Byte  <= '0;
         o_Req_Ack  <= '0;
         o_Req_Done <= '0;
         o_Err      <= 1'b0;
         o_Busy     <= 1'b0;
         cnt        <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         last       <= last_nxt;
         o_Grant_Id <= grant_nxt;
         o_Tx_DV    <= tx_dv_nxt;
         o_Tx_Byte  <= tx_byte_nxt;
         o_Req_Ack  <= ack_nxt;
         o_Req_Done <= done_nxt;
         o_Err      <= err_nxt;
         o_Busy     <= busy_nxt;
         cnt        <= cnt_nxt;
         gap_cnt    <= gap_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx model, a stub for watchdog cases,
// and a second instance with a 5-clock gap driven by hand.
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int CPB = 4;
   localparam int TO  = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  req_dv, ack, done;
   logic [31:0] req_byte;
   logic        err, busy, tx_dv, tx_active, tx_done;
   logic [2:0]  gid;
   logic [7:0]  tx_byte;

   logic        use_stub = 1'b0, stub_active = 1'b0, stub_done = 1'b0;

   logic [3:0]  req_dv1, ack1, done1;
   logic [31:0] req_byte1;
   logic        err1, busy1, tx_dv1, tx_active1, tx_done1;
   logic [2:0]  gid1;
   logic [7:0]  tx_byte1;

   int          m_state = 0, m_clk = 0, m_bit = 0;
   logic        m_active = 1'b0, m_done = 1'b0, m_line = 1'b1;
   logic [9:0]  m_sh = '1;

   assign tx_active = use_stub ? stub_active : m_active;
   assign tx_done   = use_stub ? stub_done   : m_done;

   uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) dut (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
      .o_Req_Ack(ack), .o_Req_Done(done), .o_Err(err), .o_Busy(busy),
      .o_Grant_Id(gid), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
      .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
   );

   uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(5), .TIMEOUT_CLKS(TO)) dut_gap (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(req_dv1), .i_Req_Byte(req_byte1),
      .o_Req_Ack(ack1), .o_Req_Done(done1), .o_Err(err1), .o_Busy(busy1),
      .o_Grant_Id(gid1), .o_Tx_DV(tx_dv1), .o_Tx_Byte(tx_byte1),
      .i_Tx_Active(tx_active1), .i_Tx_Done(tx_done1)
   );

   // Transmitter model: no reset, start/8 data/stop at CPB clocks each, Done high 2 cycles.
   always @(posedge clk) begin
      case (m_state)
         0: begin
            m_done <= 1'b0;
            m_line <= 1'b1;
            if (tx_dv && !use_stub) begin
               m_active <= 1'b1;
               m_sh     <= {1'b1, tx_byte, 1'b0};
               m_line   <= 1'b0;
               m_bit    <= 0;
               m_clk    <= 0;
               m_state  <= 1;
            end
         end
         1: begin
            if (m_clk == CPB - 1) begin
               m_clk <= 0;
               if (m_bit == 9) begin
                  m_done   <= 1'b1;
                  m_active <= 1'b0;
                  m_line   <= 1'b1;
                  m_state  <= 2;
               end else begin
                  m_bit  <= m_bit + 1;
                  m_line <= m_sh[m_bit + 1];
               end
            end else begin
               m_clk <= m_clk + 1;
            end
         end
         default: begin
            m_done  <= 1'b1;
            m_state <= 0;
         end
      endcase
   end

   int checks = 0, errors = 0;
   int mon_err = 0, done_cnt = 0, err_cnt = 0;
   logic [3:0] prev_ack = '0, prev_done = '0;
   logic prev_err = 1'b0, prev_dv = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones(ack) > 1 || $countones(done) > 1 ||
             (ack != 0 && prev_ack != 0) || (done != 0 && prev_done != 0) ||
             (err && prev_err) || (tx_dv && prev_dv) ||
             (tx_dv && !use_stub && (m_active || m_done))) begin
            mon_err <= mon_err + 1;
            $display("FAIL pulse_rules: ack=%b done=%b err=%b dv=%b active=%b txdone=%b",
                     ack, done, err, tx_dv, m_active, m_done);
         end
         if (done != 0) done_cnt <= done_cnt + 1;
         if (err) err_cnt <= err_cnt + 1;
      end
      prev_ack  <= ack;
      prev_done <= done;
      prev_err  <= err;
      prev_dv   <= tx_dv;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name, input int budget);
      checks++;
      errors++;
      $display("FAIL %s: no pulse within %0d cycles", name, budget);
   endtask

   task automatic wait_ack(input string name, output int idx, input int budget);
      int n = 0;
      idx = -1;
      while (idx < 0 && n < budget) begin
         @(negedge clk);
         n++;
         for (int r = 0; r < NR; r++) if (ack[r]) idx = r;
      end
      if (idx < 0) timeout_fail(name, budget);
   endtask

   task automatic wait_done(input string name, output int idx, input int budget);
      int n = 0;
      idx = -1;
      while (idx < 0 && n < budget) begin
         @(negedge clk);
         n++;
         for (int r = 0; r < NR; r++) if (done[r]) idx = r;
      end
      if (idx < 0) timeout_fail(name, budget);
   endtask

   typedef struct {
      bit          do_rst;
      logic [3:0]  raise;
      logic [3:0]  keep;
      logic [31:0] bytes;
      int          exp_id;
      logic [7:0]  exp_byte;
      bit          chk_idle;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int idx, didx, n, first_done, done_before;
      bit saw_done;
      logic [9:0] line_bits;

      vecs[0]  = '{1, 4'b0010, 4'b0000, 32'h0000_A500, 1, 8'hA5, 1};
      vecs[1]  = '{1, 4'b1111, 4'b1110, 32'h1312_1110, 0, 8'h10, 0};
      vecs[2]  = '{0, 4'b0000, 4'b1100, 32'h1312_1110, 1, 8'h11, 0};
      vecs[3]  = '{0, 4'b0000, 4'b1000, 32'h1312_1110, 2, 8'h12, 0};
      vecs[4]  = '{0, 4'b0000, 4'b0000, 32'h1312_1110, 3, 8'h13, 1};
      vecs[5]  = '{1, 4'b0101, 4'b0101, 32'h00C2_00C0, 0, 8'hC0, 0};
      vecs[6]  = '{0, 4'b0000, 4'b0101, 32'h00C2_00C0, 2, 8'hC2, 0};
      vecs[7]  = '{0, 4'b0000, 4'b0101, 32'h00C2_00C0, 0, 8'hC0, 0};
      vecs[8]  = '{0, 4'b0000, 4'b0101, 32'h00C2_00C0, 2, 8'hC2, 0};
      vecs[9]  = '{0, 4'b0000, 4'b0101, 32'h00C2_00C0, 0, 8'hC0, 0};
      vecs[10] = '{0, 4'b0000, 4'b0000, 32'h00C2_00C0, 2, 8'hC2, 1};

      rst_n = 1'b0; req_dv = '0; req_byte = '0;
      req_dv1 = '0; req_byte1 = '0; tx_active1 = 1'b0; tx_done1 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_gid", 32'(gid), 0);
      check("rst_tx_dv", 32'(tx_dv), 0);
      check("rst_tx_byte", 32'(tx_byte), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_rst) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         req_byte = vecs[i].bytes;
         req_dv   = req_dv | vecs[i].raise;
         wait_ack($sformatf("v%0d_ack", i), idx, 80);
         check($sformatf("v%0d_ack_id", i), idx, vecs[i].exp_id);
         check($sformatf("v%0d_gid", i), 32'(gid), vecs[i].exp_id);
         check($sformatf("v%0d_tx_dv", i), 32'(tx_dv), 1);
         check($sformatf("v%0d_tx_byte", i), 32'(tx_byte), 32'(vecs[i].exp_byte));
         req_dv = req_dv & vecs[i].keep;
         if (i == 0) begin
            repeat (2) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
               line_bits[b] = m_line;
               if (b < 9) repeat (4) @(negedge clk);
            end
            check("v0_line", 32'(line_bits), 32'({1'b1, vecs[0].exp_byte, 1'b0}));
         end
         wait_done($sformatf("v%0d_done", i), didx, 80);
         check($sformatf("v%0d_done_id", i), didx, vecs[i].exp_id);
         if (vecs[i].chk_idle) begin
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(busy), 0);
         end
      end

      // Transmitter never goes active: activity watchdog after 4 cycles in S_WAIT_ACT.
      use_stub = 1'b1;
      req_byte = 32'h0000_7700;
      req_dv   = 4'b0010;
      wait_ack("wa_ack", idx, 20);
      check("wa_ack_id", idx, 1);
      req_dv = '0;
      n = 0;
      while (!err && n < 20) begin @(negedge clk); n++; end
      check("wa_err_delay", n, 5);
      repeat (3) @(negedge clk);
      check("wa_idle", 32'(busy), 0);

      // Active stuck high, Done never comes: completion watchdog 60 cycles into S_WAIT_DONE.
      req_byte = 32'h0000_0088;
      req_dv   = 4'b0001;
      wait_ack("wd_ack", idx, 20);
      check("wd_ack_id", idx, 0);
      stub_active = 1'b1;
      req_dv = '0;
      n = 0; saw_done = 1'b0;
      while (!err && n < 100) begin
         @(negedge clk);
         n++;
         if (done != 0) saw_done = 1'b1;
      end
      check("wd_err_delay", n, 62);
      check("wd_no_done", 32'(saw_done), 0);
      repeat (4) @(negedge clk);
      stub_active = 1'b0;
      repeat (3) @(negedge clk);
      check("wd_idle", 32'(busy), 0);
      use_stub = 1'b0;

      // Reset during data bit 3 with req3 pending.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_byte = 32'h5A00_003C;
      req_dv   = 4'b0001;
      wait_ack("mr_ack0", idx, 20);
      check("mr_ack0_id", idx, 0);
      req_dv = 4'b1000;
      repeat (18) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mr_rst_busy", 32'(busy), 0);
      check("mr_model_active", 32'(m_active), 1);
      done_before = done_cnt;
      rst_n = 1'b1;
      wait_ack("mr_ack3", idx, 60);
      check("mr_ack3_id", idx, 3);
      check("mr_tx_byte", 32'(tx_byte), 32'h5A);
      check("mr_no_stray_done", done_cnt, done_before);
      req_dv = '0;
      wait_done("mr_done", didx, 80);
      check("mr_done_id", didx, 3);

      // Second instance, GAP_CLKS=5, transmitter handshake driven by hand.
      req_byte1 = 32'h0000_2221;
      req_dv1   = 4'b0011;
      n = 0;
      while (ack1 == 0 && n < 20) begin @(negedge clk); n++; end
      check("gap_first_ack", 32'(ack1), 32'b0001);
      req_dv1 = 4'b0010;
      tx_active1 = 1'b1;
      repeat (10) @(negedge clk);
      tx_active1 = 1'b0;
      tx_done1   = 1'b1;
      n = 0; first_done = -1;
      while (tx_dv1 == 0 && n < 30) begin
         @(negedge clk);
         n++;
         if (n == 2) tx_done1 = 1'b0;
         if (done1 != 0 && first_done < 0) first_done = n;
      end
      check("gap_dv_delay", n, 8);
      check("gap_done_at", first_done, 1);
      check("gap_second_ack", 32'(ack1), 32'b0010);
      check("gap_tx_byte", 32'(tx_byte1), 32'h22);
      req_dv1 = '0;

      @(negedge clk);
      #1;
      check("done_count", done_cnt, 12);
      check("err_count", err_cnt, 2);
      check("pulse_rules", mon_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

endmodule
